// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results, inserts bubbles while the divider
// is busy, holds on stall, clears on flush, and kills writes for faulting instructions.
module ex_mem_reg #(
  parameter int          BUBBLE_CNT_W  = 16,
  parameter logic [31:0] EXC_KILL_MASK = 32'h0000_0C00
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  input  logic                    ex_ok_i,
  input  logic                    ex_valid_i,
  input  logic [31:0]             ex_pc_i,
  input  logic                    ex_in_delay_slot_i,
  input  logic [7:0]              ex_aluop_i,
  input  logic [4:0]              ex_wd_i,
  input  logic                    ex_wreg_i,
  input  logic [63:0]             ex_wdata_i,
  input  logic                    ex_whilo_i,
  input  logic [31:0]             ex_mem_addr_i,
  input  logic [31:0]             ex_store_data_i,
  input  logic [31:0]             ex_exception_type_i,
  input  logic                    ex_cp0_we_i,
  input  logic [4:0]              ex_cp0_waddr_i,
  input  logic [31:0]             ex_cp0_wdata_i,
  output logic                    mem_valid_o,
  output logic [31:0]             mem_pc_o,
  output logic                    mem_in_delay_slot_o,
  output logic [7:0]              mem_aluop_o,
  output logic [4:0]              mem_wd_o,
  output logic                    mem_wreg_o,
  output logic [63:0]             mem_wdata_o,
  output logic                    mem_whilo_o,
  output logic [31:0]             mem_mem_addr_o,
  output logic [31:0]             mem_store_data_o,
  output logic [31:0]             mem_exception_type_o,
  output logic                    mem_cp0_we_o,
  output logic [4:0]              mem_cp0_waddr_o,
  output logic [31:0]             mem_cp0_wdata_o,
  output logic                    stallreq_ex_o,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                    w_kill;
  logic                    w_capture;
  logic                    w_bubble;
  logic                    w_div_busy;
  logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

  assign stallreq_ex_o = ~ex_ok_i & ex_valid_i;

  // Priority: flush > stall > divider busy > empty slot > capture.
  always_comb begin
    w_kill     = |(ex_exception_type_i & EXC_KILL_MASK);
    w_capture  = ~flush_i & ~stall_i & ex_valid_i & ex_ok_i;
    w_bubble   = flush_i | (~stall_i & ~(ex_valid_i & ex_ok_i));
    w_div_busy = ~flush_i & ~stall_i & ex_valid_i & ~ex_ok_i;
  end

  // EX -> MEM stage boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || w_bubble) begin
      mem_valid_o          <= 1'b0;
      mem_pc_o             <= '0;
      mem_in_delay_slot_o  <= 1'b0;
      mem_aluop_o          <= '0;
      mem_wd_o             <= '0;
      mem_wreg_o           <= 1'b0;
      mem_wdata_o          <= '0;
      mem_whilo_o          <= 1'b0;
      mem_mem_addr_o       <= '0;
      mem_store_data_o     <= '0;
      mem_exception_type_o <= '0;
      mem_cp0_we_o         <= 1'b0;
      mem_cp0_waddr_o      <= '0;
      mem_cp0_wdata_o      <= '0;
    end else if (w_capture) begin
      mem_valid_o          <= 1'b1;
      mem_pc_o             <= ex_pc_i;
      mem_in_delay_slot_o  <= ex_in_delay_slot_i;
      mem_aluop_o          <= ex_aluop_i;
      mem_wd_o             <= ex_wd_i;
      mem_wreg_o           <= ex_wreg_i & ~w_kill;
      mem_wdata_o          <= ex_wdata_i;
      mem_whilo_o          <= ex_whilo_i & ~w_kill;
      mem_mem_addr_o       <= ex_mem_addr_i;
      mem_store_data_o     <= ex_store_data_i;
      mem_exception_type_o <= ex_exception_type_i;
      mem_cp0_we_o         <= ex_cp0_we_i & ~w_kill;
      mem_cp0_waddr_o      <= ex_cp0_waddr_i;
      mem_cp0_wdata_o      <= ex_cp0_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_bubble_cnt <= '0;
    else if (w_div_busy)
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
  end

  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, capture, divider bubbles, exception kill,
// stall hold, flush priority and asynchronous reset.
module tb_ex_mem_reg;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, stall_i, ex_ok_i, ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_in_delay_slot_i;
  logic [7:0]  ex_aluop_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic [63:0] ex_wdata_i;
  logic        ex_whilo_i;
  logic [31:0] ex_mem_addr_i, ex_store_data_i, ex_exception_type_i;
  logic        ex_cp0_we_i;
  logic [4:0]  ex_cp0_waddr_i;
  logic [31:0] ex_cp0_wdata_i;

  logic        mem_valid_o;
  logic [31:0] mem_pc_o;
  logic        mem_in_delay_slot_o;
  logic [7:0]  mem_aluop_o;
  logic [4:0]  mem_wd_o;
  logic        mem_wreg_o;
  logic [63:0] mem_wdata_o;
  logic        mem_whilo_o;
  logic [31:0] mem_mem_addr_o, mem_store_data_o, mem_exception_type_o;
  logic        mem_cp0_we_o;
  logic [4:0]  mem_cp0_waddr_o;
  logic [31:0] mem_cp0_wdata_o;
  logic        stallreq_ex_o;
  logic [15:0] bubble_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_mem_reg #(.BUBBLE_CNT_W(16), .EXC_KILL_MASK(32'h0000_0C00)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .ex_ok_i(ex_ok_i), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_in_delay_slot_i(ex_in_delay_slot_i), .ex_aluop_i(ex_aluop_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .ex_whilo_i(ex_whilo_i), .ex_mem_addr_i(ex_mem_addr_i),
    .ex_store_data_i(ex_store_data_i), .ex_exception_type_i(ex_exception_type_i),
    .ex_cp0_we_i(ex_cp0_we_i), .ex_cp0_waddr_i(ex_cp0_waddr_i),
    .ex_cp0_wdata_i(ex_cp0_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_pc_o(mem_pc_o),
    .mem_in_delay_slot_o(mem_in_delay_slot_o), .mem_aluop_o(mem_aluop_o),
    .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_wdata_o(mem_wdata_o),
    .mem_whilo_o(mem_whilo_o), .mem_mem_addr_o(mem_mem_addr_o),
    .mem_store_data_o(mem_store_data_o), .mem_exception_type_o(mem_exception_type_o),
    .mem_cp0_we_o(mem_cp0_we_o), .mem_cp0_waddr_o(mem_cp0_waddr_o),
    .mem_cp0_wdata_o(mem_cp0_wdata_o), .stallreq_ex_o(stallreq_ex_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush_i = 0; stall_i = 0; ex_ok_i = 1; ex_valid_i = 0;
    ex_pc_i = '0; ex_in_delay_slot_i = 0; ex_aluop_i = '0; ex_wd_i = '0;
    ex_wreg_i = 0; ex_wdata_i = '0; ex_whilo_i = 0; ex_mem_addr_i = '0;
    ex_store_data_i = '0; ex_exception_type_i = '0; ex_cp0_we_i = 0;
    ex_cp0_waddr_i = '0; ex_cp0_wdata_i = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk_i);
    check_val("rst_valid", mem_valid_o, 0);
    check_val("rst_wdata", mem_wdata_o, 0);
    check_val("rst_cnt", bubble_cnt_o, 0);
    rst_i = 1'b0;

    // ADDU capture
    ex_valid_i = 1; ex_ok_i = 1; ex_wd_i = 5; ex_wreg_i = 1; ex_pc_i = 32'h0000_0100;
    ex_aluop_i = 8'h21; ex_wdata_i = 64'h0000_0003_0000_0003;
    ex_mem_addr_i = 32'hA000_0010; ex_store_data_i = 32'hCAFE_0001;
    #1 check_val("addu_stallreq", stallreq_ex_o, 0);
    @(negedge clk_i);
    check_val("addu_wd", mem_wd_o, 5);
    check_val("addu_wreg", mem_wreg_o, 1);
    check_val("addu_wdata_lo", mem_wdata_o[31:0], 3);
    check_val("addu_valid", mem_valid_o, 1);
    check_val("addu_pc", mem_pc_o, 32'h0000_0100);
    check_val("addu_aluop", mem_aluop_o, 8'h21);
    check_val("addu_maddr", mem_mem_addr_o, 32'hA000_0010);
    check_val("addu_sdata", mem_store_data_o, 32'hCAFE_0001);

    // Divider running for 33 cycles
    clear_inputs();
    ex_valid_i = 1; ex_ok_i = 0;
    for (int i = 0; i < 33; i++) begin
      #1 check_val($sformatf("div_stallreq%0d", i), stallreq_ex_o, 1);
      @(negedge clk_i);
      check_val($sformatf("div_valid%0d", i), mem_valid_o, 0);
    end
    check_val("div_cnt", bubble_cnt_o, 33);
    ex_ok_i = 1; ex_whilo_i = 1; ex_wdata_i = 64'h0000_0001_0000_0007;
    #1 check_val("div_done_stallreq", stallreq_ex_o, 0);
    @(negedge clk_i);
    check_val("div_whilo", mem_whilo_o, 1);
    check_val("div_wdata", mem_wdata_o, 64'h0000_0001_0000_0007);
    check_val("div_cnt_after", bubble_cnt_o, 33);

    // Overflow kills all writes but keeps fault info
    clear_inputs();
    ex_valid_i = 1; ex_wreg_i = 1; ex_whilo_i = 1; ex_cp0_we_i = 1;
    ex_exception_type_i = 32'h0000_0800; ex_pc_i = 32'h0000_0200; ex_in_delay_slot_i = 1;
    @(negedge clk_i);
    check_val("ov_wreg", mem_wreg_o, 0);
    check_val("ov_whilo", mem_whilo_o, 0);
    check_val("ov_cp0we", mem_cp0_we_o, 0);
    check_val("ov_exc", mem_exception_type_o, 32'h0000_0800);
    check_val("ov_pc", mem_pc_o, 32'h0000_0200);
    check_val("ov_ds", mem_in_delay_slot_o, 1);

    // Trap bit also kills; an unmasked exception bit does not
    ex_exception_type_i = 32'h0000_0400;
    @(negedge clk_i);
    check_val("trap_wreg", mem_wreg_o, 0);
    ex_exception_type_i = 32'h0000_0200;
    @(negedge clk_i);
    check_val("other_wreg", mem_wreg_o, 1);

    // Empty slot: bubble without counting
    clear_inputs();
    ex_valid_i = 0; ex_ok_i = 0;
    #1 check_val("empty_stallreq", stallreq_ex_o, 0);
    @(negedge clk_i);
    check_val("empty_valid", mem_valid_o, 0);
    check_val("empty_cnt", bubble_cnt_o, 33);

    // MTC0 then stall for 3 cycles while inputs change
    clear_inputs();
    ex_valid_i = 1; ex_cp0_we_i = 1; ex_cp0_waddr_i = 12; ex_cp0_wdata_i = 32'h1234_5678;
    @(negedge clk_i);
    check_val("mtc0_we", mem_cp0_we_o, 1);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      ex_cp0_we_i = 0; ex_cp0_waddr_i = 5'(i + 1); ex_cp0_wdata_i = 32'hFFFF_0000 + i;
      ex_ok_i = (i != 1);
      @(negedge clk_i);
      check_val($sformatf("stall_we%0d", i), mem_cp0_we_o, 1);
      check_val($sformatf("stall_addr%0d", i), mem_cp0_waddr_o, 12);
      check_val($sformatf("stall_data%0d", i), mem_cp0_wdata_o, 32'h1234_5678);
      check_val($sformatf("stall_valid%0d", i), mem_valid_o, 1);
    end
    check_val("stall_cnt", bubble_cnt_o, 33);

    // Flush beats stall and divider busy
    stall_i = 1; flush_i = 1; ex_valid_i = 1; ex_ok_i = 0;
    @(negedge clk_i);
    check_val("flush_valid", mem_valid_o, 0);
    check_val("flush_cp0we", mem_cp0_we_o, 0);
    check_val("flush_cp0addr", mem_cp0_waddr_o, 0);
    check_val("flush_cp0data", mem_cp0_wdata_o, 0);
    check_val("flush_cnt", bubble_cnt_o, 33);

    // Asynchronous reset between edges
    clear_inputs();
    ex_valid_i = 1; ex_pc_i = 32'h0000_0300; ex_wreg_i = 1; ex_wdata_i = 64'h55;
    @(negedge clk_i);
    check_val("pre_rst_valid", mem_valid_o, 1);
    #2 rst_i = 1;
    #1;
    check_val("arst_valid", mem_valid_o, 0);
    check_val("arst_pc", mem_pc_o, 0);
    check_val("arst_wdata", mem_wdata_o, 0);
    check_val("arst_cnt", bubble_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    check_val("post_rst_valid", mem_valid_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
